// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the unified-memory port arbiter.
//   arb_state_e : sequencer state (IDLE, BUSY_IF, BUSY_D)
//   REQ_IF/REQ_D: bit positions of the requesters in one-hot grant vectors
//   NUM_REQ     : number of requesters sharing the memory port
//   STARVE_W    : width of the fetch starvation counter
// ----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_e;

  localparam int REQ_IF   = 0;
  localparam int REQ_D    = 1;
  localparam int NUM_REQ  = 2;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_prio_sel.sv
// ----------------------------------------------------------------------------
// arb_prio_sel
// Combinational priority select between the fetch and data requesters.
// Data wins by default; fetch wins when the starvation limit has been
// reached and fetch is requesting.
//   if_req_i  : fetch request
//   d_req_i   : data request
//   starved_i : starvation counter has reached its limit
//   gnt_oh_o  : one-hot selection, bit REQ_IF / REQ_D (all-zero when idle)
// ----------------------------------------------------------------------------
module arb_prio_sel
  import arb_pkg::*;
(
  input  logic               if_req_i,
  input  logic               d_req_i,
  input  logic               starved_i,
  output logic [NUM_REQ-1:0] gnt_oh_o
);

  always_comb begin
    gnt_oh_o = '0;
    if (d_req_i && !(starved_i && if_req_i)) begin
      gnt_oh_o[REQ_D] = 1'b1;
    end else if (if_req_i) begin
      gnt_oh_o[REQ_IF] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port request/acknowledge memory between the instruction
// fetch path and the load/store path. One transaction is outstanding at a
// time. Data accesses have priority; a saturating starvation counter forces a
// fetch grant after STARVE_MAX consecutive data grants taken while fetch was
// waiting.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   if_req/if_addr        : fetch request, held until if_gnt
//   if_gnt                : one-cycle pulse, fetch accepted
//   if_rvalid/if_rdata    : one-cycle pulse with fetched word
//   d_req/d_we/d_addr/d_wdata : data request, held until d_gnt
//   d_gnt                 : one-cycle pulse, data accepted
//   d_rvalid/d_rdata      : one-cycle pulse, load data / store completion
//   mem_req/mem_we/mem_addr/mem_wdata : registered memory request fields
//   mem_ack/mem_rdata     : memory completion and read data
// ----------------------------------------------------------------------------
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  // Saturating increment of the starvation counter.
  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
    if (cnt >= STARVE_LIM) begin
      return STARVE_LIM;
    end
    return cnt + STARVE_W'(1);
  endfunction

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;

  logic                starved;
  logic [NUM_REQ-1:0]  sel_oh;
  logic                if_gnt_c, d_gnt_c;

  assign starved = (starve_cnt_q == STARVE_LIM);

  arb_prio_sel u_prio_sel (
    .if_req_i  (if_req),
    .d_req_i   (d_req),
    .starved_i (starved),
    .gnt_oh_o  (sel_oh)
  );

  // Next-state, grant and field-capture logic.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_rvalid_d  = 1'b0;
    d_rvalid_d   = 1'b0;
    if_gnt_c     = 1'b0;
    d_gnt_c      = 1'b0;

    case (state_q)
      IDLE: begin
        // mem_ack seen here belongs to no transaction and is ignored.
        if (sel_oh[REQ_D]) begin
          d_gnt_c      = 1'b1;
          state_d      = BUSY_D;
          mem_req_d    = 1'b1;
          mem_we_d     = d_we;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
          // Only count data grants that made fetch wait.
          starve_cnt_d = if_req ? starve_inc(starve_cnt_q) : '0;
        end else if (sel_oh[REQ_IF]) begin
          if_gnt_c     = 1'b1;
          state_d      = BUSY_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          starve_cnt_d = '0;
        end
      end

      BUSY_IF: begin
        if (mem_ack) begin
          if_rdata_d  = mem_rdata;
          if_rvalid_d = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          state_d     = IDLE;
        end
      end

      BUSY_D: begin
        if (mem_ack) begin
          // Captured for stores too; the requester ignores it there.
          d_rdata_d  = mem_rdata;
          d_rvalid_d = 1'b1;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_rvalid_q  <= if_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
    end
  end

  // Grants are combinational from IDLE; hold them low while reset is applied.
  assign if_gnt    = if_gnt_c & ~reset;
  assign d_gnt     = d_gnt_c & ~reset;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. A small memory
// responder acknowledges after a programmable number of wait cycles and
// returns words from a fixed table.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        resp_ack = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic        spur_ack = 1'b0;
  logic [31:0] spur_rdata = '0;
  int          wait_cfg = 0;
  int          wcnt = 0;

  int          total = 0;
  int          bad = 0;

  assign mem_ack   = resp_ack | spur_ack;
  assign mem_rdata = spur_ack ? spur_rdata : resp_rdata;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0513;
      32'h0000_0004: return 32'h0010_0593;
      32'h0000_0008: return 32'h00b5_0633;
      32'h0000_0010: return 32'h1234_5678;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Memory responder: ack on the (wait_cfg+1)-th cycle of mem_req.
  always begin
    @(posedge clk);
    #1;
    if (mem_req) begin
      if (wcnt >= wait_cfg) begin
        resp_ack   = 1'b1;
        resp_rdata = mem_word(mem_addr);
        wcnt       = 0;
      end else begin
        resp_ack = 1'b0;
        wcnt     = wcnt + 1;
      end
    end else begin
      resp_ack = 1'b0;
      wcnt     = 0;
    end
  end

  // Grants and responses are mutually exclusive every cycle.
  always @(negedge clk) begin
    total++;
    if ((if_gnt && d_gnt) || (if_rvalid && d_rvalid)) begin
      bad++;
      $display("FAIL exclusive: gnt=%b%b rvalid=%b%b required no overlap",
               if_gnt, d_gnt, if_rvalid, d_rvalid);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_wdata = '0;
    tick();
    mid();
    total++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we} !== 6'b0) begin
      bad++;
      $display("FAIL rst_ctrl: got %b required 000000",
               {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we});
    end
    total++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_memfields: addr=%h wdata=%h required 0", mem_addr, mem_wdata);
    end
    total++;
    if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_rdata: if=%h d=%h required 0", if_rdata, d_rdata);
    end
  endtask

  task automatic test_simul_release();
    reset = 1'b0;
    #1;
    total++;
    if ({if_gnt, d_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL simul_first: gnt if/d=%b required 01", {if_gnt, d_gnt});
    end
    tick();
    d_req = 1'b0;
    mid();
    total++;
    if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h10 || if_gnt !== 1'b0) begin
      bad++;
      $display("FAIL simul_busy: req/we=%b addr=%h if_gnt=%b required 10 00000010 0",
               {mem_req, mem_we}, mem_addr, if_gnt);
    end
    tick();
    mid();
    total++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h1234_5678) begin
      bad++;
      $display("FAIL simul_drvalid: rvalid=%b data=%h required 1 12345678", d_rvalid, d_rdata);
    end
    total++;
    if (if_gnt !== 1'b1) begin
      bad++;
      $display("FAIL simul_ifgnt: if_gnt=%b required 1", if_gnt);
    end
    tick();
    if_req = 1'b0;
    mid();
    total++;
    if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL simul_ifbusy: req/we=%b addr=%h required 10 00000000",
               {mem_req, mem_we}, mem_addr);
    end
    tick();
    mid();
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h0000_0513) begin
      bad++;
      $display("FAIL simul_ifrvalid: rvalid=%b data=%h required 1 00000513", if_rvalid, if_rdata);
    end
    tick();
  endtask

  task automatic test_fetch_only();
    logic [31:0] addrs [3];
    logic [31:0] words [3];
    addrs[0] = 32'h00; addrs[1] = 32'h04; addrs[2] = 32'h08;
    words[0] = 32'h0000_0513; words[1] = 32'h0010_0593; words[2] = 32'h00b5_0633;
    wait_cfg = 0;
    if_req = 1'b1;
    if_addr = addrs[0];
    mid();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({if_gnt, d_gnt} !== 2'b10) begin
        bad++;
        $display("FAIL fetch_gnt[%0d]: gnt if/d=%b required 10", i, {if_gnt, d_gnt});
      end
      tick();
      if (i < 2) if_addr = addrs[i+1];
      else if_req = 1'b0;
      mid();
      total++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== addrs[i] || if_gnt !== 1'b0) begin
        bad++;
        $display("FAIL fetch_busy[%0d]: req=%b we=%b addr=%h gnt=%b required 1 0 %h 0",
                 i, mem_req, mem_we, mem_addr, if_gnt, addrs[i]);
      end
      tick();
      mid();
      total++;
      if (if_rvalid !== 1'b1 || if_rdata !== words[i]) begin
        bad++;
        $display("FAIL fetch_rvalid[%0d]: rvalid=%b data=%h required 1 %h",
                 i, if_rvalid, if_rdata, words[i]);
      end
    end
    total++;
    if (if_gnt !== 1'b0) begin
      bad++;
      $display("FAIL fetch_nogrant: if_gnt=%b required 0", if_gnt);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic [9:0] exp_if;
    int n;
    exp_if = 10'b10_0001_0000;  // grants 4 and 9 go to fetch
    n = 0;
    wait_cfg = 0;
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = '0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      mid();
      if (if_gnt || d_gnt) begin
        total++;
        if (if_gnt !== exp_if[n]) begin
          bad++;
          $display("FAIL starve_order[%0d]: if_gnt=%b d_gnt=%b required if_gnt=%b",
                   n, if_gnt, d_gnt, exp_if[n]);
        end
        n++;
      end
      tick();
    end
    if_req = 1'b0;
    d_req = 1'b0;
    total++;
    if (n != 10) begin
      bad++;
      $display("FAIL starve_count: grants=%0d required 10", n);
    end
    repeat (3) tick();
  endtask

  task automatic test_store_wait();
    logic seen;
    wait_cfg = 2;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h0C;
    mid();
    total++;
    if ({if_gnt, d_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL store_gnt: gnt if/d=%b required 01", {if_gnt, d_gnt});
    end
    tick();
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    for (int j = 0; j < 3; j++) begin
      mid();
      total++;
      if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h20 || mem_wdata !== 32'hDEAD_BEEF) begin
        bad++;
        $display("FAIL store_fields[%0d]: req/we=%b addr=%h wdata=%h required 11 00000020 deadbeef",
                 j, {mem_req, mem_we}, mem_addr, mem_wdata);
      end
      total++;
      if (if_gnt !== 1'b0 || d_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL store_wait[%0d]: if_gnt=%b d_rvalid=%b required 0 0", j, if_gnt, d_rvalid);
      end
      tick();
    end
    mid();
    total++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hA5A5_0020 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL store_done: rvalid=%b data=%h mem_req=%b required 1 a5a50020 0",
               d_rvalid, d_rdata, mem_req);
    end
    total++;
    if (if_gnt !== 1'b1) begin
      bad++;
      $display("FAIL store_ifgnt: if_gnt=%b required 1", if_gnt);
    end
    tick();
    if_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      mid();
      if (if_rvalid) seen = 1'b1;
      else tick();
    end
    total++;
    if (seen !== 1'b1 || if_rdata !== 32'hA5A5_000C) begin
      bad++;
      $display("FAIL store_fetch: seen=%b data=%h required 1 a5a5000c", seen, if_rdata);
    end
    tick();
    wait_cfg = 0;
  endtask

  task automatic test_reset_mid();
    logic seen;
    logic saw_d;
    wait_cfg = 5;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
    mid();
    total++;
    if (d_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rmid_gnt: d_gnt=%b required 1", d_gnt);
    end
    tick();
    d_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h44;
    mid();
    total++;
    if (mem_req !== 1'b1 || if_gnt !== 1'b0) begin
      bad++;
      $display("FAIL rmid_busy: mem_req=%b if_gnt=%b required 1 0", mem_req, if_gnt);
    end
    tick();
    mid();
    reset = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL rmid_memreq: mem_req=%b required 0", mem_req);
    end
    total++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_we} !== 5'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      bad++;
      $display("FAIL rmid_outs: ctl=%b addr=%h wdata=%h ifd=%h dd=%h required all 0",
               {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_we}, mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    tick();
    mid();
    total++;
    if (d_rvalid !== 1'b0 || if_gnt !== 1'b0) begin
      bad++;
      $display("FAIL rmid_hold: d_rvalid=%b if_gnt=%b required 0 0", d_rvalid, if_gnt);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({if_gnt, d_gnt} !== 2'b10) begin
      bad++;
      $display("FAIL rmid_release: gnt if/d=%b required 10", {if_gnt, d_gnt});
    end
    tick();
    if_req = 1'b0;
    seen = 1'b0;
    saw_d = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      mid();
      if (d_rvalid) saw_d = 1'b1;
      if (if_rvalid) seen = 1'b1;
      else tick();
    end
    total++;
    if (seen !== 1'b1 || saw_d !== 1'b0 || if_rdata !== 32'hA5A5_0044) begin
      bad++;
      $display("FAIL rmid_after: if_seen=%b d_seen=%b data=%h required 1 0 a5a50044",
               seen, saw_d, if_rdata);
    end
    tick();
    wait_cfg = 0;
  endtask

  task automatic test_spurious_ack();
    spur_rdata = 32'hCAFE_F00D;
    spur_ack = 1'b1;
    mid();
    total++;
    if ({if_rvalid, d_rvalid, mem_req} !== 3'b000) begin
      bad++;
      $display("FAIL spur_during: rvalid if/d=%b mem_req=%b required 00 0",
               {if_rvalid, d_rvalid}, mem_req);
    end
    tick();
    spur_ack = 1'b0;
    mid();
    total++;
    if ({if_rvalid, d_rvalid, mem_req} !== 3'b000) begin
      bad++;
      $display("FAIL spur_after: rvalid if/d=%b mem_req=%b required 00 0",
               {if_rvalid, d_rvalid}, mem_req);
    end
    total++;
    if (if_rdata !== 32'hA5A5_0044 || d_rdata !== 32'h0) begin
      bad++;
      $display("FAIL spur_rdata: if=%h d=%h required a5a50044 00000000", if_rdata, d_rdata);
    end
    if_req = 1'b1;
    if_addr = 32'h04;
    #1;
    total++;
    if (if_gnt !== 1'b1) begin
      bad++;
      $display("FAIL spur_idle: if_gnt=%b required 1", if_gnt);
    end
    tick();
    if_req = 1'b0;
    mid();
    tick();
    mid();
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h0010_0593) begin
      bad++;
      $display("FAIL spur_fetch: rvalid=%b data=%h required 1 00100593", if_rvalid, if_rdata);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_simul_release();
    test_fetch_only();
    test_starvation();
    test_store_wait();
    test_reset_mid();
    test_spurious_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
